// File: rtl/dct_pkg.sv
// Shared sizing and bank-state encoding for the 4x4 DCT transpose scheduler.
package dct_pkg;

    localparam int DW     = 22;
    localparam int N      = 4;
    localparam int WCNT_W = $clog2(N * N);
    localparam int CCNT_W = $clog2(N);
    localparam int FCNT_W = $clog2(N) + 1;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

endpackage

// File: rtl/dct_lane_fifo.sv
// Single lane FIFO: W bits by DEPTH entries, registered read data, synchronous clear.
module dct_lane_fifo
    import dct_pkg::*;
#(
    parameter int W     = DW,
    parameter int DEPTH = N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   wr_en_i,
    input  logic [W-1:0]           wr_data_i,
    input  logic                   rd_en_i,
    output logic [W-1:0]           rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  rd_data_q;

    // Storage carries no reset; only pointers, count and the read register do.
    always_ff @(posedge clk) begin
        if (wr_en_i && !clr_i) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
        end else if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en_i) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (rd_en_i) begin
                rd_data_q <= mem_q[rptr_q];
                rptr_q    <= rptr_q + PW'(1);
            end
            case ({wr_en_i, rd_en_i})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign rd_data_o = rd_data_q;
    assign full_o    = (cnt_q == CW'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign count_o   = cnt_q;

endmodule

// File: rtl/dct_transpose_sched.sv
// Transpose scheduler between the row and column DCT passes: coefficients arrive
// serially in row-major order and leave as whole columns from a ping-pong pair of banks.
module dct_transpose_sched
    import dct_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*DW-1:0] out_data,
    output logic            out_last,
    output logic            block_done
);

    // Both interfaces: a transfer happens on a cycle with valid && ready; the
    // producer holds valid and data stable until that cycle.

    bank_state_e         bank_q [2];
    logic                wr_bank_q;
    logic                rd_bank_q;
    logic [WCNT_W-1:0]   wcnt_q;
    logic [CCNT_W-1:0]   ccnt_q;

    logic                infl_q;
    logic                infl_last_q;
    logic                infl_bank_q;

    logic [1:0][N*DW-1:0] skid_q, skid_d;
    logic [1:0]           skid_last_q, skid_last_d;
    logic [1:0]           sk_cnt_q, sk_cnt_d;

    bank_state_e         wr_state;
    bank_state_e         rd_state;
    logic                wr_open;
    logic                wr_fire;
    logic                wr_last;
    logic [CCNT_W-1:0]   wr_lane;
    logic                flush_clr;
    logic                pop_ok;
    logic                pop;
    logic                rd_last;
    logic                out_fire;
    logic                sk_push;
    logic                sk_pop;
    logic [N*DW-1:0]     col_data;

    logic [DW-1:0]                 lane_rd [2][N];
    logic [2*N-1:0]                lane_full;
    logic [2*N-1:0]                lane_empty;
    logic [2*N-1:0][FCNT_W-1:0]    lane_cnt;
    logic                          unused_lane_status;

    assign wr_state  = bank_q[wr_bank_q];
    assign rd_state  = bank_q[rd_bank_q];
    assign wr_open   = (wr_state == BANK_EMPTY) || (wr_state == BANK_FILLING);
    assign in_ready  = wr_open && !flush && !rst;
    assign wr_fire   = in_valid && in_ready;
    assign wr_last   = (wcnt_q == WCNT_W'(N * N - 1));
    assign wr_lane   = wcnt_q[WCNT_W-1 -: CCNT_W];
    assign flush_clr = flush && wr_open;

    // Pops are limited so that buffered plus in-flight columns never exceed two.
    assign pop_ok  = (sk_cnt_q == 2'd0) || ((sk_cnt_q == 2'd1) && !infl_q);
    assign pop     = ((rd_state == BANK_FULL) || (rd_state == BANK_DRAINING)) && pop_ok;
    assign rd_last = (ccnt_q == CCNT_W'(N - 1));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar l = 0; l < N; l++) begin : g_lane
            dct_lane_fifo #(
                .W     (DW),
                .DEPTH (N)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .clr_i     (flush_clr && (wr_bank_q == 1'(b))),
                .wr_en_i   (wr_fire && (wr_bank_q == 1'(b)) && (wr_lane == CCNT_W'(l))),
                .wr_data_i (in_data),
                .rd_en_i   (pop && (rd_bank_q == 1'(b))),
                .rd_data_o (lane_rd[b][l]),
                .full_o    (lane_full[b*N+l]),
                .empty_o   (lane_empty[b*N+l]),
                .count_o   (lane_cnt[b*N+l])
            );
        end
    end

    assign unused_lane_status = ^{lane_full, lane_empty, lane_cnt};

    always_comb begin
        col_data = '0;
        for (int i = 0; i < N; i++) begin
            col_data[i*DW +: DW] = lane_rd[infl_bank_q][i];
        end
    end

    // A column arriving from the FIFOs is handed straight out when the skid is
    // empty and downstream is ready; otherwise it queues behind older columns.
    assign out_valid  = (sk_cnt_q != 2'd0) || infl_q;
    assign out_data   = (sk_cnt_q != 2'd0) ? skid_q[0] : col_data;
    assign out_last   = (sk_cnt_q != 2'd0) ? skid_last_q[0] : (infl_q && infl_last_q);
    assign out_fire   = out_valid && out_ready;
    assign block_done = out_fire && out_last;
    assign sk_pop     = out_ready && (sk_cnt_q != 2'd0);
    assign sk_push    = infl_q && !((sk_cnt_q == 2'd0) && out_ready);

    always_comb begin
        skid_d      = skid_q;
        skid_last_d = skid_last_q;
        sk_cnt_d    = sk_cnt_q;
        if (sk_pop) begin
            skid_d[0]      = skid_q[1];
            skid_last_d[0] = skid_last_q[1];
            sk_cnt_d       = sk_cnt_q - 2'd1;
        end
        if (sk_push) begin
            skid_d[sk_cnt_d[0]]      = col_data;
            skid_last_d[sk_cnt_d[0]] = infl_last_q;
            sk_cnt_d                 = sk_cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0]   <= BANK_EMPTY;
            bank_q[1]   <= BANK_EMPTY;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wcnt_q      <= '0;
            ccnt_q      <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            infl_bank_q <= 1'b0;
            skid_q      <= '0;
            skid_last_q <= '0;
            sk_cnt_q    <= '0;
        end else begin
            // The write bank is always EMPTY/FILLING and the read bank FULL/DRAINING
            // when they act, so the two updates below never hit the same bank.
            if (flush_clr) begin
                bank_q[wr_bank_q] <= BANK_EMPTY;
                wcnt_q            <= '0;
            end else if (wr_fire) begin
                wcnt_q <= wcnt_q + WCNT_W'(1);
                if (wr_last) begin
                    bank_q[wr_bank_q] <= BANK_FULL;
                    wr_bank_q         <= ~wr_bank_q;
                end else if (wr_state == BANK_EMPTY) begin
                    bank_q[wr_bank_q] <= BANK_FILLING;
                end
            end
            if (pop) begin
                ccnt_q      <= ccnt_q + CCNT_W'(1);
                infl_bank_q <= rd_bank_q;
                if (rd_last) begin
                    bank_q[rd_bank_q] <= BANK_EMPTY;
                    rd_bank_q         <= ~rd_bank_q;
                end else if (rd_state == BANK_FULL) begin
                    bank_q[rd_bank_q] <= BANK_DRAINING;
                end
            end
            infl_q      <= pop;
            infl_last_q <= pop && rd_last;
            skid_q      <= skid_d;
            skid_last_q <= skid_last_d;
            sk_cnt_q    <= sk_cnt_d;
        end
    end

endmodule
